// File: rtl/bin_to_bcd_pkg.sv
// Shared constants for the signed binary to BCD converter: state encodings,
// the blanked-digit code and the saturation limit.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    BCD_IDLE  = 2'd0,
    BCD_SHIFT = 2'd1,
    BCD_DONE  = 2'd2
  } bcd_state_e;

  localparam int DATA_W = 11;
  localparam int STAGES = 10;

  localparam logic [3:0] OFF     = 4'hF;
  localparam logic [9:0] BCD_MAX = 10'd999;
  localparam logic [3:0] CNT_TOP = 4'(STAGES - 1);

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decade.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential 11-bit signed binary to 3-digit BCD converter (one bit per clock).
// Optional leading-zero blanking on the result digits: define BIN_TO_BCD_BLANK_EN.
module bin_to_bcd
  import bin_to_bcd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bin_in,
  output logic              busy,
  output logic              done,
  output logic [3:0]        out_ones,
  output logic [3:0]        out_tens,
  output logic [3:0]        out_huns,
  output logic              negative,
  output logic              overflow
);

  bcd_state_e state_q, state_d;

  logic [3:0]  cnt_q;
  logic        sign_q;
  logic        nz_q;
  logic        ovf_q;
  logic [9:0]  mag_q;
  logic [11:0] scr_q;

  logic [3:0]  ones_adj, tens_adj, huns_adj;
  logic [21:0] shifted;
  logic        accept;
  logic        last_shift;
  logic [10:0] mag_in;

  function automatic logic [10:0] abs11(input logic signed [DATA_W-1:0] v);
    logic [10:0] u;
    u = v;
    return v[DATA_W-1] ? (~u + 11'd1) : u;
  endfunction

  function automatic logic [9:0] sat999(input logic [10:0] m);
    return (m > 11'(BCD_MAX)) ? BCD_MAX : m[9:0];
  endfunction

  function automatic logic [11:0] blank(input logic [11:0] s);
    logic [11:0] r;
    r = s;
`ifdef BIN_TO_BCD_BLANK_EN
    if (s[11:8] == 4'd0) begin
      r[11:8] = OFF;
      if (s[7:4] == 4'd0) r[7:4] = OFF;
    end
`endif
    return r;
  endfunction

  assign accept     = (state_q == BCD_IDLE) && start;
  assign last_shift = (state_q == BCD_SHIFT) && (cnt_q == 4'd0);
  assign mag_in     = abs11(bin_in);

  always_ff @(posedge clk) begin
    if (rst) state_q <= BCD_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BCD_IDLE:  if (start) state_d = BCD_SHIFT;
      BCD_SHIFT: if (cnt_q == 4'd0) state_d = BCD_DONE;
      BCD_DONE:  state_d = BCD_IDLE;
      default:   state_d = BCD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                         cnt_q <= 4'd0;
    else if (accept)                 cnt_q <= CNT_TOP;
    else if (state_q == BCD_SHIFT)   cnt_q <= cnt_q - 4'd1;
  end

  // Shift stage: correct each scratch digit, then shift magnitude MSB into ones LSB
  bcd_add3 u_add_ones (.d(scr_q[3:0]),  .q(ones_adj));
  bcd_add3 u_add_tens (.d(scr_q[7:4]),  .q(tens_adj));
  bcd_add3 u_add_huns (.d(scr_q[11:8]), .q(huns_adj));

  assign shifted = {huns_adj, tens_adj, ones_adj, mag_q} << 1;

  always_ff @(posedge clk) begin
    if (accept) begin
      sign_q <= bin_in[DATA_W-1];
      nz_q   <= |mag_in;
      ovf_q  <= (mag_in > 11'(BCD_MAX));
      mag_q  <= sat999(mag_in);
      scr_q  <= 12'd0;
    end else if (state_q == BCD_SHIFT) begin
      scr_q  <= shifted[21:10];
      mag_q  <= shifted[9:0];
    end
  end

  // Result stage: loaded on the final shift so the digits appear with done
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ones <= 4'd0;
      out_tens <= 4'd0;
      out_huns <= 4'd0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else if (last_shift) begin
      {out_huns, out_tens, out_ones} <= blank(shifted[21:10]);
      negative <= sign_q & nz_q;
      overflow <= ovf_q;
    end
  end

  assign busy = (state_q == BCD_SHIFT);
  assign done = (state_q == BCD_DONE);

endmodule

// File: tb/tb_bin_to_bcd.sv
// Scoreboard bench for bin_to_bcd: driver pushes expected results from an
// arithmetic reference model, a monitor pops and compares on every done.
module tb_bin_to_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] bin_in = 11'd0;
  logic        busy, done, negative, overflow;
  logic [3:0]  out_ones, out_tens, out_huns;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done_cyc = -1;
  int prev_done_cyc = -1;

  typedef struct {
    logic [3:0] h, t, o;
    logic       n, v;
    int         t0;
  } exp_t;

  exp_t sb[$];

  bin_to_bcd dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done),
    .out_ones(out_ones), .out_tens(out_tens), .out_huns(out_huns),
    .negative(negative), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t model(input logic [10:0] v, input int t0);
    exp_t e;
    int s, mag, m;
    s   = (v >= 11'd1024) ? int'(v) - 2048 : int'(v);
    mag = (s < 0) ? -s : s;
    m   = (mag > 999) ? 999 : mag;
    e.h = 4'(m / 100);
    e.t = 4'((m / 10) % 10);
    e.o = 4'(m % 10);
    e.n = (s < 0) && (mag != 0);
    e.v = (mag > 999);
    e.t0 = t0;
`ifdef BIN_TO_BCD_BLANK_EN
    if (m < 100) e.h = 4'hF;
    if (m < 10)  e.t = 4'hF;
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done seen at cycle %0d, required no done", cyc);
      end else begin
        e = sb.pop_front();
        if ({out_huns, out_tens, out_ones, negative, overflow} !== {e.h, e.t, e.o, e.n, e.v}) begin
          errors++;
          $display("FAIL result: got h/t/o=%h/%h/%h neg=%b ovf=%b, required %h/%h/%h neg=%b ovf=%b",
                   out_huns, out_tens, out_ones, negative, overflow, e.h, e.t, e.o, e.n, e.v);
        end
        checks++;
        if (cyc - e.t0 != 11) begin
          errors++;
          $display("FAIL latency: got %0d cycles, required 11", cyc - e.t0);
        end
      end
    end
  end

  task automatic check_cleared(input string name);
    checks++;
    if ({busy, done, out_huns, out_tens, out_ones, negative, overflow} !== 17'd0) begin
      errors++;
      $display("FAIL %s: got busy=%b done=%b h/t/o=%h/%h/%h neg=%b ovf=%b, required all 0",
               name, busy, done, out_huns, out_tens, out_ones, negative, overflow);
    end
  endtask

  // One conversion; start issued in the first IDLE cycle after the call.
  // poke re-asserts start mid-SHIFT with a different operand.
  task automatic convert(input logic [10:0] v, input bit poke);
    int bc;
    bit seen;
    logic [11:0] snap;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    sb.push_back(model(v, cyc));
    @(negedge clk);
    start  = 1'b0;
    bin_in = 11'($urandom_range(0, 2047));
    snap = {out_huns, out_tens, out_ones};
    bc = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) begin
        bc++;
        checks++;
        if ({out_huns, out_tens, out_ones} !== snap) begin
          errors++;
          $display("FAIL hold_during_shift: got %h, required %h", {out_huns, out_tens, out_ones}, snap);
        end
      end
      if (poke && i == 3) begin
        start  = 1'b1;
        bin_in = 11'd777;
      end else begin
        start  = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: operand %h got no done within 20 cycles, required done", v);
    end
    checks++;
    if (bc != 10) begin
      errors++;
      $display("FAIL busy_cycles: got %0d, required 10", bc);
    end
  endtask

  initial begin
    logic [10:0] dir [7];
    int w;
    dir = '{11'd0, 11'd255, 11'h7DB, 11'd1023, 11'h400, 11'd999, 11'h7FF};

    repeat (3) @(negedge clk);
    check_cleared("reset_state");
    start  = 1'b1;
    bin_in = 11'd500;
    @(negedge clk);
    check_cleared("start_with_reset");
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check_cleared("idle_after_reset");

    for (int i = 0; i < 7; i++) convert(dir[i], 1'b0);

    convert(11'd321, 1'b1);
    repeat (15) @(negedge clk);

    convert(11'd42, 1'b0);
    convert(11'h79C, 1'b0);
    #1;
    checks++;
    if (last_done_cyc - prev_done_cyc != 12) begin
      errors++;
      $display("FAIL back_to_back: got done spacing %0d, required 12", last_done_cyc - prev_done_cyc);
    end

    // Reset five cycles into SHIFT aborts the conversion silently
    @(negedge clk);
    start  = 1'b1;
    bin_in = 11'd658;
    @(negedge clk);
    start  = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_cleared("mid_shift_reset");
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check_cleared("no_done_after_abort");
    convert(11'd100, 1'b0);

    for (int i = 0; i < 30; i++) begin
      w = $urandom_range(0, 3);
      repeat (w) @(negedge clk);
      convert(11'($urandom_range(0, 2047)), 1'b0);
    end

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
